// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing a 2R1W SRAM among NRD read clients and NWR write
// clients, with registered read return and same-cycle write-to-read forwarding.
module sram_port_arbiter #(
  parameter int NRD = 4,
  parameter int NWR = 2,
  parameter int AW  = 16,
  parameter int DW  = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NRD-1:0]    rd_req,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_gnt,
  output logic [NRD-1:0]    rd_rvalid,
  output logic [NRD*DW-1:0] rd_rdata,
  input  logic [NWR-1:0]    wr_req,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*DW-1:0] wr_data,
  output logic [NWR-1:0]    wr_gnt,
  output logic              WE,
  output logic [AW-1:0]     WriteAddress,
  output logic [DW-1:0]     WriteBus,
  output logic [AW-1:0]     ReadAddress1,
  output logic [AW-1:0]     ReadAddress2,
  input  logic [DW-1:0]     ReadBus1,
  input  logic [DW-1:0]     ReadBus2
);

  localparam int RPW = (NRD > 1) ? $clog2(NRD) : 1;
  localparam int WPW = (NWR > 1) ? $clog2(NWR) : 1;

  logic [RPW-1:0] rdPtr;
  logic [RPW-1:0] rdPtrNext;
  logic [RPW-1:0] port1Idx;
  logic [RPW-1:0] port2Idx;
  logic [RPW-1:0] lastRdIdx;
  logic           port1Valid;
  logic           port2Valid;
  logic [WPW-1:0] wrPtr;
  logic [WPW-1:0] wrPtrNext;
  logic [WPW-1:0] wrIdx;
  logic           wrValid;
  logic [DW-1:0]  port1Data;
  logic [DW-1:0]  port2Data;
  logic [NRD-1:0] rvalidReg;

  logic [AW-1:0] rdAddrArr [NRD];
  logic [AW-1:0] wrAddrArr [NWR];
  logic [DW-1:0] wrDataArr [NWR];
  logic [DW-1:0] rdataReg  [NRD];

  for (genvar g = 0; g < NRD; g++) begin : gRdUnpack
    assign rdAddrArr[g]            = rd_addr[g*AW +: AW];
    assign rd_rdata[g*DW +: DW]    = rdataReg[g];
  end

  for (genvar g = 0; g < NWR; g++) begin : gWrUnpack
    assign wrAddrArr[g] = wr_addr[g*AW +: AW];
    assign wrDataArr[g] = wr_data[g*DW +: DW];
  end

  // Cyclic scan from rdPtr: first requester takes port 1, second takes port 2.
  always_comb begin
    int idx;
    logic [RPW-1:0] scanIdx;
    idx        = 0;
    scanIdx    = '0;
    port1Valid = 1'b0;
    port2Valid = 1'b0;
    port1Idx   = '0;
    port2Idx   = '0;
    for (int k = 0; k < NRD; k++) begin
      idx = int'(rdPtr) + k;
      if (idx >= NRD) idx = idx - NRD;
      scanIdx = RPW'(idx);
      if (reset_n && rd_req[scanIdx]) begin
        if (!port1Valid) begin
          port1Valid = 1'b1;
          port1Idx   = scanIdx;
        end else if (!port2Valid) begin
          port2Valid = 1'b1;
          port2Idx   = scanIdx;
        end
      end
    end
  end

  always_comb begin
    int idx;
    logic [WPW-1:0] scanIdx;
    idx     = 0;
    scanIdx = '0;
    wrValid = 1'b0;
    wrIdx   = '0;
    for (int k = 0; k < NWR; k++) begin
      idx = int'(wrPtr) + k;
      if (idx >= NWR) idx = idx - NWR;
      scanIdx = WPW'(idx);
      if (reset_n && wr_req[scanIdx] && !wrValid) begin
        wrValid = 1'b1;
        wrIdx   = scanIdx;
      end
    end
  end

  always_comb begin
    rd_gnt = '0;
    if (port1Valid) rd_gnt[port1Idx] = 1'b1;
    if (port2Valid) rd_gnt[port2Idx] = 1'b1;
    wr_gnt = '0;
    if (wrValid) wr_gnt[wrIdx] = 1'b1;
  end

  // The pointer moves past the last client served, so a lone requester keeps winning.
  always_comb begin
    lastRdIdx = port2Valid ? port2Idx : port1Idx;
    rdPtrNext = rdPtr;
    if (port1Valid) rdPtrNext = (lastRdIdx == RPW'(NRD-1)) ? '0 : lastRdIdx + 1'b1;
    wrPtrNext = wrPtr;
    if (wrValid) wrPtrNext = (wrIdx == WPW'(NWR-1)) ? '0 : wrIdx + 1'b1;
  end

  assign ReadAddress1 = port1Valid ? rdAddrArr[port1Idx] : '0;
  assign ReadAddress2 = port2Valid ? rdAddrArr[port2Idx] : '0;
  assign WE           = wrValid;
  assign WriteAddress = wrValid ? wrAddrArr[wrIdx] : '0;
  assign WriteBus     = wrValid ? wrDataArr[wrIdx] : '0;

  // The SRAM only commits the write at the edge, so a colliding read takes the bus value.
  assign port1Data = (wrValid && (WriteAddress == ReadAddress1)) ? WriteBus : ReadBus1;
  assign port2Data = (wrValid && (WriteAddress == ReadAddress2)) ? WriteBus : ReadBus2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      rvalidReg <= '0;
      for (int i = 0; i < NRD; i++) rdataReg[i] <= '0;
    end else begin
      rdPtr     <= rdPtrNext;
      wrPtr     <= wrPtrNext;
      rvalidReg <= rd_gnt;
      for (int i = 0; i < NRD; i++) begin
        if (port1Valid && (port1Idx == RPW'(i)))      rdataReg[i] <= port1Data;
        else if (port2Valid && (port2Idx == RPW'(i))) rdataReg[i] <= port2Data;
      end
    end
  end

  assign rd_rvalid = rvalidReg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: an SRAM macro model drives the read
// buses and a queue-based round-robin reference model predicts every output.
module tb_sram_port_arbiter;

  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int AW  = 16;
  localparam int DW  = 128;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NRD-1:0]    rd_req;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD-1:0]    rd_gnt;
  logic [NRD-1:0]    rd_rvalid;
  logic [NRD*DW-1:0] rd_rdata;
  logic [NWR-1:0]    wr_req;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR-1:0]    wr_gnt;
  logic              WE;
  logic [AW-1:0]     WriteAddress;
  logic [DW-1:0]     WriteBus;
  logic [AW-1:0]     ReadAddress1;
  logic [AW-1:0]     ReadAddress2;
  logic [DW-1:0]     ReadBus1;
  logic [DW-1:0]     ReadBus2;

  int nChecks = 0;
  int nPass   = 0;

  sram_port_arbiter #(.NRD(NRD), .NWR(NWR), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .WE(WE), .WriteAddress(WriteAddress), .WriteBus(WriteBus),
    .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
    .ReadBus1(ReadBus1), .ReadBus2(ReadBus2)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
    return {4{a ^ 16'hA5A5, ~a}};
  endfunction

  // SRAM macro: preloaded contents come from initVal until a word is written.
  logic [DW-1:0] sramMem     [0:65535];
  bit            sramWritten [0:65535];

  always @(posedge clock) begin
    if (WE) begin
      sramMem[WriteAddress]     <= WriteBus;
      sramWritten[WriteAddress] <= 1'b1;
    end
  end

  assign ReadBus1 = sramWritten[ReadAddress1] ? sramMem[ReadAddress1] : initVal(ReadAddress1);
  assign ReadBus2 = sramWritten[ReadAddress2] ? sramMem[ReadAddress2] : initVal(ReadAddress2);

  int             mRdPtr = 0;
  int             mWrPtr = 0;
  logic [NRD-1:0] mRvalid = '0;
  logic [DW-1:0]  mRdata [NRD];
  logic [NRD-1:0] lastRdGnt = '0;
  logic [NWR-1:0] lastWrGnt = '0;
  logic [DW-1:0]  refMem [int];

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    if (refMem.exists(int'(a))) return refMem[int'(a)];
    return initVal(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    mRdPtr  = 0;
    mWrPtr  = 0;
    mRvalid = '0;
    for (int i = 0; i < NRD; i++) mRdata[i] = '0;
  endtask

  // Drives one cycle, compares all outputs with the model, then advances the model.
  task automatic applyStimulus(input logic rstN, input logic [NRD-1:0] rq,
                               input logic [NRD*AW-1:0] ra, input logic [NWR-1:0] wq,
                               input logic [NWR*AW-1:0] wa, input logic [NWR*DW-1:0] wd);
    int             served[$];
    int             wIdx;
    logic [NRD-1:0] expRdGnt;
    logic [NWR-1:0] expWrGnt;
    logic           expWe;
    logic [AW-1:0]  expWa;
    logic [DW-1:0]  expWd;
    logic [AW-1:0]  expRa1;
    logic [AW-1:0]  expRa2;
    logic [AW-1:0]  a;
    reset_n = rstN;
    rd_req  = rq;
    rd_addr = ra;
    wr_req  = wq;
    wr_addr = wa;
    wr_data = wd;
    #1;
    wIdx = -1;
    expRdGnt = '0; expWrGnt = '0; expWe = 1'b0;
    expWa = '0; expWd = '0; expRa1 = '0; expRa2 = '0;
    if (rstN) begin
      for (int k = 0; k < NRD; k++)
        if (rq[(mRdPtr + k) % NRD] && served.size() < 2) served.push_back((mRdPtr + k) % NRD);
      for (int k = 0; k < NWR; k++)
        if (wq[(mWrPtr + k) % NWR] && wIdx < 0) wIdx = (mWrPtr + k) % NWR;
      foreach (served[j]) expRdGnt[served[j]] = 1'b1;
      if (served.size() > 0) expRa1 = ra[served[0]*AW +: AW];
      if (served.size() > 1) expRa2 = ra[served[1]*AW +: AW];
      if (wIdx >= 0) begin
        expWrGnt[wIdx] = 1'b1;
        expWe = 1'b1;
        expWa = wa[wIdx*AW +: AW];
        expWd = wd[wIdx*DW +: DW];
      end
    end
    checkOutput("rd_gnt", rd_gnt, expRdGnt);
    checkOutput("wr_gnt", wr_gnt, expWrGnt);
    checkOutput("WE", WE, expWe);
    checkOutput("WriteAddress", WriteAddress, expWa);
    checkOutput("WriteBus", WriteBus, expWd);
    checkOutput("ReadAddress1", ReadAddress1, expRa1);
    checkOutput("ReadAddress2", ReadAddress2, expRa2);
    checkOutput("rd_rvalid", rd_rvalid, mRvalid);
    for (int i = 0; i < NRD; i++)
      checkOutput($sformatf("rd_rdata%0d", i), rd_rdata[i*DW +: DW], mRdata[i]);
    if (!rstN) begin
      modelReset();
    end else begin
      mRvalid = expRdGnt;
      foreach (served[j]) begin
        a = ra[served[j]*AW +: AW];
        mRdata[served[j]] = (expWe && expWa == a) ? expWd : refRead(a);
      end
      if (served.size() > 0) mRdPtr = (served[served.size()-1] + 1) % NRD;
      if (expWe) begin
        refMem[int'(expWa)] = expWd;
        mWrPtr = (wIdx + 1) % NWR;
      end
    end
    lastRdGnt = expRdGnt;
    lastWrGnt = expWrGnt;
  endtask

  task automatic resetCycle();
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    @(negedge clock);
  endtask

  function automatic logic [AW-1:0] pickAddr();
    case ($urandom % 4)
      0:       return 16'h0010;
      1:       return 16'hFFFF;
      2:       return AW'($urandom % 4);
      default: return AW'($urandom);
    endcase
  endfunction

  logic [NRD-1:0]    curRq;
  logic [NRD*AW-1:0] curRa;
  logic [NWR-1:0]    curWq;
  logic [NWR*AW-1:0] curWa;
  logic [NWR*DW-1:0] curWd;
  logic [DW-1:0]     wordFFFF;

  initial begin
    for (int i = 0; i < NRD; i++) mRdata[i] = '0;
    wordFFFF = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    // Reset held with every client requesting, then release.
    reset_n = 1'b0; rd_req = '1; rd_addr = '0; wr_req = '1; wr_addr = '0; wr_data = '0;
    @(negedge clock);
    applyStimulus(1'b0, 4'b1111, {16'h3, 16'h2, 16'h1, 16'h0}, 2'b11, {16'h9, 16'h8}, {128'h2, 128'h1});
    checkOutput("resetRdGnt", rd_gnt, 4'b0000);
    checkOutput("resetWE", WE, 1'b0);
    @(negedge clock);
    applyStimulus(1'b1, 4'b1111, {16'h3, 16'h2, 16'h1, 16'h0}, 2'b11, {16'h9, 16'h8}, {128'h2, 128'h1});
    checkOutput("firstRdGnt", rd_gnt, 4'b0011);
    checkOutput("firstWrGnt", wr_gnt, 2'b01);
    @(negedge clock);

    // All four readers held: pairs alternate.
    resetCycle();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 4'b1111, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, '0, '0, '0);
      checkOutput($sformatf("pairGnt%0d", c), rd_gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      @(negedge clock);
    end
    applyStimulus(1'b1, '0, '0, '0, '0, '0);
    checkOutput("pairData3", rd_rdata[3*DW +: DW], initVal(16'h0103));
    @(negedge clock);

    // Same-cycle write and read of 0x0010 forwards the write data.
    resetCycle();
    applyStimulus(1'b1, 4'b0100, {16'h0, 16'h0010, 16'h0, 16'h0}, 2'b01,
                  {16'h0, 16'h0010}, {128'h0, 128'hDEAD_BEEF});
    @(negedge clock);
    applyStimulus(1'b1, '0, '0, '0, '0, '0);
    checkOutput("fwdValid", rd_rvalid[2], 1'b1);
    checkOutput("fwdData", rd_rdata[2*DW +: DW], 128'hDEAD_BEEF);
    @(negedge clock);

    // Both writers held alternate; the top address reads back intact.
    resetCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, '0, '0, 2'b11, {16'h0020, 16'hFFFF}, {128'h2222, wordFFFF});
      checkOutput($sformatf("wrGnt%0d", c), wr_gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clock);
    end
    applyStimulus(1'b1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'hFFFF}, '0, '0, '0);
    @(negedge clock);
    applyStimulus(1'b1, '0, '0, '0, '0, '0);
    checkOutput("topAddrData", rd_rdata[0 +: DW], wordFFFF);
    @(negedge clock);

    // A lone client 3 wins every cycle on port 1; then 0 and 3 share.
    resetCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'b1000, {16'h0333, 16'h0, 16'h0, 16'h0}, '0, '0, '0);
      checkOutput("loneGnt", rd_gnt, 4'b1000);
      checkOutput("loneRa1", ReadAddress1, 16'h0333);
      checkOutput("loneRa2", ReadAddress2, 16'h0000);
      @(negedge clock);
    end
    applyStimulus(1'b1, 4'b1001, {16'h0333, 16'h0, 16'h0, 16'h0444}, '0, '0, '0);
    checkOutput("shareGnt", rd_gnt, 4'b1001);
    checkOutput("shareRa1", ReadAddress1, 16'h0444);
    checkOutput("shareRa2", ReadAddress2, 16'h0333);
    @(negedge clock);

    // Reset arriving right after a grant suppresses the return pulse.
    resetCycle();
    applyStimulus(1'b1, 4'b0010, {16'h0, 16'h0, 16'h0555, 16'h0}, '0, '0, '0);
    checkOutput("preResetGnt", rd_gnt, 4'b0010);
    reset_n = 1'b0;
    modelReset();
    @(negedge clock);
    applyStimulus(1'b1, '0, '0, '0, '0, '0);
    checkOutput("postResetValid", rd_rvalid[1], 1'b0);
    @(negedge clock);
    applyStimulus(1'b1, 4'b1111, {16'h3, 16'h2, 16'h1, 16'h0}, '0, '0, '0);
    checkOutput("postResetGnt", rd_gnt, 4'b0011);
    @(negedge clock);

    // Random traffic obeying the hold-until-grant rule.
    curRq = '0; curRa = '0; curWq = '0; curWa = '0; curWd = '0;
    lastRdGnt = '0; lastWrGnt = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NRD; i++) begin
        if (!(curRq[i] && !lastRdGnt[i] && ($urandom % 10 != 0))) begin
          curRq[i] = ($urandom % 3 != 0);
          curRa[i*AW +: AW] = pickAddr();
        end
      end
      for (int i = 0; i < NWR; i++) begin
        if (!(curWq[i] && !lastWrGnt[i] && ($urandom % 10 != 0))) begin
          curWq[i] = ($urandom % 2 == 0);
          curWa[i*AW +: AW] = pickAddr();
          curWd[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      applyStimulus(1'b1, curRq, curRa, curWq, curWa, curWd);
      @(negedge clock);
    end

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
